// File: rtl/ctrl_seq_pkg.sv
// Shared types for the instruction sequencer: FSM states, instruction
// classes and opcode bit positions used by the control unit.
package common;

  typedef enum logic [2:0] {
    FETCH_REQ  = 3'd0,
    FETCH_WAIT = 3'd1,
    DECODE     = 3'd2,
    EXEC       = 3'd3,
    MEM_REQ    = 3'd4,
    MEM_WAIT   = 3'd5,
    WB         = 3'd6,
    ERROR      = 3'd7
  } ctrl_state_t;

  // Instruction class lives in the two most significant IR bits.
  typedef enum logic [1:0] {
    CLS_ALU = 2'b00,
    CLS_MEM = 2'b01,
    CLS_IMM = 2'b10,
    CLS_JMP = 2'b11
  } instr_class_t;

  // Opcode bit 0 selects store (1) versus load (0) for memory instructions.
  localparam int OPC_STORE_BIT = 0;

  // States in which the sequencer is waiting on the memory handshake.
  function automatic logic isMemState(input ctrl_state_t s);
    return (s == FETCH_REQ) || (s == FETCH_WAIT) ||
           (s == MEM_REQ)   || (s == MEM_WAIT);
  endfunction

endpackage

// File: rtl/ctrl_seq_watchdog.sv
// Handshake watchdog: counts consecutive enabled cycles and flags expiry
// on the cycle the count would reach TIMEOUT.
module ctrl_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_count;

  // Cycle counter; saturates so it can never wrap back to a safe value.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != CNT_W'(TIMEOUT))) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Expiry is flagged during the TIMEOUT-th waiting cycle so the FSM leaves
  // the memory state after exactly TIMEOUT cycles.
  always_comb begin
    o_expired = i_enable && (r_count >= CNT_W'(TIMEOUT - 1));
  end

endmodule

// File: rtl/ctrl_seq.sv
// Multi-cycle instruction sequencer: fetches over the ready handshake,
// decodes four instruction classes, sequences execute, load/store and
// write-back, owns the program counter and trips a watchdog on a stuck bus.
module ctrl_seq
  import common::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 16,
  parameter int OPC_W   = 6,
  parameter int REG_AW  = 5,
  parameter int LIT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  input  logic [DATA_W-1:0] data,
  output logic              fetch,
  output logic              Valid,
  output logic              RW,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] pc,
  output logic [OPC_W-1:0]  opcode,
  output logic [REG_AW-1:0] oppA,
  output logic [REG_AW-1:0] oppB,
  output logic [DATA_W-1:0] literal,
  output logic              exec_en,
  input  logic              exec_done,
  output logic              regEn,
  output logic              err
);

  ctrl_state_t       r_state;
  ctrl_state_t       w_stateNext;
  logic [DATA_W-1:0] r_ir;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pcNext;

  instr_class_t      w_decClass;
  logic [OPC_W-1:0]  w_decOpcode;
  logic [REG_AW-1:0] w_decOppA;
  logic [REG_AW-1:0] w_decOppB;
  logic [DATA_W-1:0] w_decLiteral;
  logic [OPC_W-1:0]  w_opcodeNext;
  logic [DATA_W-1:0] w_literalNext;

  logic              w_wdClear;
  logic              w_wdEnable;
  logic              w_wdExpired;

  // Literal extension: only the immediate-ALU class sign-extends.
  function automatic logic [DATA_W-1:0] decodeLiteral(input logic [DATA_W-1:0] ir);
    logic [LIT_W-1:0] lit;
    lit = ir[LIT_W-1:0];
    if (instr_class_t'(ir[DATA_W-1 -: 2]) == CLS_IMM) begin
      return {{(DATA_W - LIT_W){lit[LIT_W-1]}}, lit};
    end
    return {{(DATA_W - LIT_W){1'b0}}, lit};
  endfunction

  // Field slicing of the held instruction word.
  always_comb begin
    w_decClass   = instr_class_t'(r_ir[DATA_W-1 -: 2]);
    w_decOpcode  = r_ir[DATA_W-1 -: OPC_W];
    w_decOppA    = r_ir[DATA_W-1-OPC_W -: REG_AW];
    w_decOppB    = r_ir[DATA_W-1-OPC_W-REG_AW -: REG_AW];
    w_decLiteral = decodeLiteral(r_ir);
  end

  // Next state and pc; a watchdog expiry overrides any handshake progress.
  always_comb begin
    w_stateNext = r_state;
    w_pcNext    = r_pc;
    case (r_state)
      FETCH_REQ:  if (!ready) w_stateNext = FETCH_WAIT;
      FETCH_WAIT: if (ready) begin
                    w_stateNext = DECODE;
                    w_pcNext    = r_pc + ADDR_W'(1);
                  end
      DECODE: begin
        case (w_decClass)
          CLS_MEM: w_stateNext = MEM_REQ;
          CLS_JMP: begin
            w_stateNext = FETCH_REQ;
            w_pcNext    = w_decLiteral[ADDR_W-1:0];
          end
          default: w_stateNext = EXEC;
        endcase
      end
      EXEC:     if (exec_done) w_stateNext = WB;
      MEM_REQ:  if (!ready) w_stateNext = MEM_WAIT;
      MEM_WAIT: if (ready) begin
                  w_stateNext = opcode[OPC_STORE_BIT] ? FETCH_REQ : WB;
                end
      WB:       w_stateNext = FETCH_REQ;
      default:  w_stateNext = ERROR;
    endcase
    if (w_wdExpired) begin
      w_stateNext = ERROR;
      w_pcNext    = r_pc;
    end
  end

  // Memory-request outputs for MEM_REQ must see the fields being decoded now.
  always_comb begin
    w_opcodeNext  = (r_state == DECODE) ? w_decOpcode  : opcode;
    w_literalNext = (r_state == DECODE) ? w_decLiteral : literal;
    w_wdEnable    = isMemState(r_state);
    w_wdClear     = (w_stateNext != r_state);
  end

  ctrl_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_wdClear),
    .i_enable (w_wdEnable),
    .o_expired(w_wdExpired)
  );

  // State register with Moore outputs registered from the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH_REQ;
      r_pc    <= '0;
      r_ir    <= '0;
      fetch   <= 1'b0;
      Valid   <= 1'b0;
      RW      <= 1'b1;
      addr    <= '0;
      opcode  <= '0;
      oppA    <= '0;
      oppB    <= '0;
      literal <= '0;
      exec_en <= 1'b0;
      regEn   <= 1'b0;
      err     <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_pc    <= w_pcNext;
      if ((r_state == FETCH_WAIT) && (w_stateNext == DECODE)) begin
        r_ir <= data;
      end
      if (r_state == DECODE) begin
        opcode  <= w_decOpcode;
        oppA    <= w_decOppA;
        oppB    <= w_decOppB;
        literal <= w_decLiteral;
      end
      exec_en <= (r_state == DECODE) && (w_stateNext == EXEC);
      regEn   <= (w_stateNext == WB);
      err     <= (w_stateNext == ERROR);
      case (w_stateNext)
        FETCH_REQ, FETCH_WAIT: begin
          Valid <= 1'b1;
          fetch <= 1'b1;
          RW    <= 1'b1;
          addr  <= w_pcNext;
        end
        MEM_REQ, MEM_WAIT: begin
          Valid <= 1'b1;
          fetch <= 1'b0;
          RW    <= ~w_opcodeNext[OPC_STORE_BIT];
          addr  <= w_literalNext[ADDR_W-1:0];
        end
        default: begin
          Valid <= 1'b0;
          fetch <= 1'b0;
          RW    <= 1'b1;
        end
      endcase
    end
  end

  assign pc = r_pc;

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for the instruction sequencer, built with a 4-cycle
// watchdog so the timeout path is reachable quickly.
module tb_ctrl_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic [31:0] data;
  logic        fetch;
  logic        Valid;
  logic        RW;
  logic [15:0] addr;
  logic [15:0] pc;
  logic [5:0]  opcode;
  logic [4:0]  oppA;
  logic [4:0]  oppB;
  logic [31:0] literal;
  logic        exec_en;
  logic        exec_done;
  logic        regEn;
  logic        err;

  int vectors = 0;
  int miscompares = 0;

  ctrl_seq #(
    .DATA_W(32), .ADDR_W(16), .OPC_W(6), .REG_AW(5), .LIT_W(16), .TIMEOUT(4)
  ) dut (
    .clk(clk), .reset(reset), .ready(ready), .data(data),
    .fetch(fetch), .Valid(Valid), .RW(RW), .addr(addr), .pc(pc),
    .opcode(opcode), .oppA(oppA), .oppB(oppB), .literal(literal),
    .exec_en(exec_en), .exec_done(exec_done), .regEn(regEn), .err(err)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic rst, input logic rdy,
                               input logic [31:0] word, input logic done);
    reset     = rst;
    ready     = rdy;
    data      = word;
    exec_done = done;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_Valid"}, 32'(Valid), 32'd0);
    checkOutput({tag, "_fetch"}, 32'(fetch), 32'd0);
    checkOutput({tag, "_RW"}, 32'(RW), 32'd1);
    checkOutput({tag, "_addr"}, 32'(addr), 32'd0);
    checkOutput({tag, "_pc"}, 32'(pc), 32'd0);
    checkOutput({tag, "_opcode"}, 32'(opcode), 32'd0);
    checkOutput({tag, "_oppA"}, 32'(oppA), 32'd0);
    checkOutput({tag, "_oppB"}, 32'(oppB), 32'd0);
    checkOutput({tag, "_literal"}, literal, 32'd0);
    checkOutput({tag, "_exec_en"}, 32'(exec_en), 32'd0);
    checkOutput({tag, "_regEn"}, 32'(regEn), 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
  endtask

  // One fetch with a single busy cycle; leaves the sequencer in DECODE.
  task automatic doFetch(input logic [15:0] expAddr, input logic [31:0] word);
    int n = 0;
    while (Valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checkOutput("fetch_valid", 32'(Valid), 32'd1);
    checkOutput("fetch_addr", 32'(addr), 32'(expAddr));
    checkOutput("fetch_flag", 32'(fetch), 32'd1);
    checkOutput("fetch_rw", 32'(RW), 32'd1);
    ready = 1'b0;
    tick();
    checkOutput("fetch_hold", 32'(Valid), 32'd1);
    ready = 1'b1;
    data  = word;
    tick();
    checkOutput("fetch_drop", 32'(Valid), 32'd0);
  endtask

  initial begin
    applyStimulus(1'b1, 1'b1, 32'h0, 1'b0);
    tick();
    tick();
    checkResetValues("reset");
    reset = 1'b0;

    // Reg-ALU, exec_done two cycles after exec_en.
    doFetch(16'h0000, 32'h0C22_0000);
    checkOutput("alu_pc_inc", 32'(pc), 32'd1);
    tick();
    checkOutput("alu_exec_en", 32'(exec_en), 32'd1);
    checkOutput("alu_opcode", 32'(opcode), 32'h03);
    checkOutput("alu_oppA", 32'(oppA), 32'd1);
    checkOutput("alu_oppB", 32'(oppB), 32'd2);
    checkOutput("alu_literal", literal, 32'd0);
    tick();
    checkOutput("alu_exec_pulse", 32'(exec_en), 32'd0);
    tick();
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    checkOutput("alu_regEn", 32'(regEn), 32'd1);
    tick();
    checkOutput("alu_regEn_pulse", 32'(regEn), 32'd0);
    checkOutput("alu_next_addr", 32'(addr), 32'd1);

    // Imm-ALU with immediate exec_done and sign-extended literal.
    doFetch(16'h0001, 32'h8000_FFFE);
    exec_done = 1'b1;
    tick();
    checkOutput("imm_exec_en", 32'(exec_en), 32'd1);
    checkOutput("imm_literal", literal, 32'hFFFF_FFFE);
    checkOutput("imm_opcode", 32'(opcode), 32'h20);
    tick();
    exec_done = 1'b0;
    checkOutput("imm_regEn", 32'(regEn), 32'd1);
    tick();
    checkOutput("imm_pc", 32'(pc), 32'd2);

    // Load: zero-extended literal drives the address.
    doFetch(16'h0002, 32'h4000_8000);
    tick();
    checkOutput("ld_valid", 32'(Valid), 32'd1);
    checkOutput("ld_fetch", 32'(fetch), 32'd0);
    checkOutput("ld_rw", 32'(RW), 32'd1);
    checkOutput("ld_addr", 32'(addr), 32'h8000);
    checkOutput("ld_literal", literal, 32'h0000_8000);
    ready = 1'b0;
    tick();
    checkOutput("ld_wait_valid", 32'(Valid), 32'd1);
    ready = 1'b1;
    tick();
    checkOutput("ld_regEn", 32'(regEn), 32'd1);
    checkOutput("ld_valid_drop", 32'(Valid), 32'd0);
    tick();
    checkOutput("ld_next_addr", 32'(addr), 32'd3);

    // Store: RW low through the handshake, no write-back.
    doFetch(16'h0003, 32'h4400_00AB);
    tick();
    checkOutput("st_opcode", 32'(opcode), 32'h11);
    checkOutput("st_rw_req", 32'(RW), 32'd0);
    checkOutput("st_addr", 32'(addr), 32'h00AB);
    ready = 1'b0;
    tick();
    checkOutput("st_rw_wait", 32'(RW), 32'd0);
    checkOutput("st_regEn_wait", 32'(regEn), 32'd0);
    ready = 1'b1;
    tick();
    checkOutput("st_regEn", 32'(regEn), 32'd0);
    checkOutput("st_fetch", 32'(fetch), 32'd1);
    checkOutput("st_rw_back", 32'(RW), 32'd1);
    checkOutput("st_next_addr", 32'(addr), 32'd4);

    // Jump to the top of memory, then fetch there so pc wraps.
    doFetch(16'h0004, 32'hC000_FFFF);
    checkOutput("jmp_pc_inc", 32'(pc), 32'd5);
    tick();
    checkOutput("jmp_addr", 32'(addr), 32'hFFFF);
    checkOutput("jmp_pc", 32'(pc), 32'hFFFF);
    doFetch(16'hFFFF, 32'hC000_1234);
    checkOutput("wrap_pc", 32'(pc), 32'd0);
    tick();
    checkOutput("wrap_jmp_addr", 32'(addr), 32'h1234);
    checkOutput("wrap_jmp_pc", 32'(pc), 32'h1234);

    // Reset in the middle of a load's MEM_WAIT.
    doFetch(16'h1234, 32'h4000_0055);
    tick();
    ready = 1'b0;
    tick();
    checkOutput("rst_mid_valid", 32'(Valid), 32'd1);
    reset = 1'b1;
    tick();
    checkResetValues("rst_mid");
    applyStimulus(1'b0, 1'b1, 32'h0, 1'b0);
    doFetch(16'h0000, 32'hC000_0010);
    checkOutput("restart_pc", 32'(pc), 32'd1);
    tick();
    checkOutput("restart_jmp_addr", 32'(addr), 32'h0010);

    // Watchdog: idle memory in FETCH_REQ trips after four cycles.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("wd_early_err", 32'(err), 32'd0);
    end
    tick();
    checkOutput("wd_err", 32'(err), 32'd1);
    checkOutput("wd_valid", 32'(Valid), 32'd0);
    checkOutput("wd_pc", 32'(pc), 32'd0);
    ready = 1'b0;
    exec_done = 1'b1;
    tick();
    tick();
    checkOutput("wd_sticky", 32'(err), 32'd1);
    checkOutput("wd_exec_en", 32'(exec_en), 32'd0);
    checkOutput("wd_regEn", 32'(regEn), 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h0, 1'b0);
    tick();
    checkResetValues("wd_reset");
    reset = 1'b0;
    tick();
    checkOutput("wd_refetch", 32'(Valid), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
